// File: rtl/dcache_flush_seq_if.sv
// Flush-sequencer bus: controller flush handshake plus tag/writeback/invalidate ports.
// master = sequencer side, slave = controller/cache side.
interface dcache_flush_seq_if #(
    parameter int NR_SETS = 2048,
    parameter int NR_WAYS = 4
);
    localparam int SET_W = $clog2(NR_SETS);
    localparam int WAY_W = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;

    logic               flush_i;
    logic               flush_ack_o;
    logic               busy_o;
    logic               tag_req_o;
    logic               tag_gnt_i;
    logic [SET_W-1:0]   tag_set_o;
    logic [NR_WAYS-1:0] tag_valid_i;
    logic [NR_WAYS-1:0] tag_dirty_i;
    logic               wb_req_o;
    logic [WAY_W-1:0]   wb_way_o;
    logic               wb_done_i;
    logic               inv_req_o;
    logic               inv_gnt_i;
    logic [31:0]        flush_cycles_o;

    modport master (
        input  flush_i, tag_gnt_i, tag_valid_i, tag_dirty_i,
        input  wb_done_i, inv_gnt_i,
        output flush_ack_o, busy_o, tag_req_o, tag_set_o,
        output wb_req_o, wb_way_o, inv_req_o, flush_cycles_o
    );

    modport slave (
        output flush_i, tag_gnt_i, tag_valid_i, tag_dirty_i,
        output wb_done_i, inv_gnt_i,
        input  flush_ack_o, busy_o, tag_req_o, tag_set_o,
        input  wb_req_o, wb_way_o, inv_req_o, flush_cycles_o
    );
endinterface

// File: rtl/dcache_flush_seq.sv
// Write-back dcache flush sequencer: walks all sets, writes back valid dirty
// ways lowest first, invalidates each set, then pulses flush_ack_o.
// Ports: clk_i, rst_ni (async active-low), bus (dcache_flush_seq_if.master).
// Optional: define DCACHE_FLUSH_PERF_CNT_EN for the flush_cycles_o counter.
module dcache_flush_seq #(
    parameter int NR_SETS = 2048,
    parameter int NR_WAYS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    dcache_flush_seq_if.master   bus
);
    localparam int SET_W = $clog2(NR_SETS);
    localparam int WAY_W = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;
    localparam logic [SET_W-1:0] LAST_SET = SET_W'(NR_SETS - 1);

    typedef enum logic [2:0] {
        IDLE, TAG_REQ, TAG_RSP, WB, INV, DONE
    } state_e;

    state_e             state_q, state_d;
    logic [SET_W-1:0]   set_q, set_d;
    logic [NR_WAYS-1:0] mask_q, mask_d;
    logic [NR_WAYS-1:0] way_oh;
    logic [WAY_W-1:0]   way_idx;
    logic [NR_WAYS-1:0] hit;

    assign hit = bus.tag_valid_i & bus.tag_dirty_i;

    // Lowest pending dirty way, as one-hot and as index.
    assign way_oh = mask_q & (~mask_q + NR_WAYS'(1));

    always_comb begin
        way_idx = '0;
        for (int i = NR_WAYS - 1; i >= 0; i--) begin
            if (mask_q[i]) way_idx = WAY_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        mask_d  = mask_q;
        unique case (state_q)
            IDLE: begin
                if (bus.flush_i) begin
                    set_d   = '0;
                    mask_d  = '0;
                    state_d = TAG_REQ;
                end
            end
            TAG_REQ: begin
                if (bus.tag_gnt_i) state_d = TAG_RSP;
            end
            TAG_RSP: begin
                mask_d  = hit;
                state_d = (|hit) ? WB : INV;
            end
            WB: begin
                if (bus.wb_done_i) begin
                    mask_d = mask_q & ~way_oh;
                    if (mask_d == '0) state_d = INV;
                end
            end
            INV: begin
                if (bus.inv_gnt_i) begin
                    if (set_q == LAST_SET) begin
                        state_d = DONE;
                    end else begin
                        set_d   = set_q + SET_W'(1);
                        state_d = TAG_REQ;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            set_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            mask_q  <= mask_d;
        end
    end

    // Requests are decoded from the state register only, so a reset
    // drops them asynchronously and grants never feed back combinationally.
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.tag_req_o   = (state_q == TAG_REQ);
    assign bus.wb_req_o    = (state_q == WB);
    assign bus.inv_req_o   = (state_q == INV);
    assign bus.flush_ack_o = (state_q == DONE);
    assign bus.tag_set_o   = set_q;
    assign bus.wb_way_o    = way_idx;

`ifdef DCACHE_FLUSH_PERF_CNT_EN
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] fc_q, fc_d;

    // Counts every busy cycle including the ack cycle; saturates at max.
    always_comb begin
        cnt_d = cnt_q;
        fc_d  = fc_q;
        if (state_q == IDLE) begin
            if (bus.flush_i) cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 32'd1;
        end
        if (state_q == DONE) fc_d = cnt_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            fc_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            fc_q  <= fc_d;
        end
    end

    assign bus.flush_cycles_o = fc_q;
`else
    assign bus.flush_cycles_o = '0;
`endif
endmodule

// File: tb/tb_dcache_flush_seq.sv
// Randomized bench for dcache_flush_seq: a cache responder with random
// grant latencies checked against an event-level flush model.
module tb_dcache_flush_seq;
    localparam int NS = 4;
    localparam int NW = 4;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_err;
    int maxd;

    logic [NW-1:0] vmem [NS];
    logic [NW-1:0] dmem [NS];
    int exp_q [$];

    dcache_flush_seq_if #(.NR_SETS(NS), .NR_WAYS(NW)) bus ();

    dcache_flush_seq #(
        .NR_SETS(NS),
        .NR_WAYS(NW)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int code(input int t, input int s, input int w);
        return t * 65536 + s * 256 + w;
    endfunction

    task automatic log_evt(input int t, input int s, input int w);
        if (exp_q.size() == 0) check("evt_extra", 32'(code(t, s, w)), 32'hffff_ffff);
        else check("evt", 32'(code(t, s, w)), 32'(exp_q.pop_front()));
    endtask

    task automatic idle_inputs();
        bus.flush_i     = 1'b0;
        bus.tag_gnt_i   = 1'b0;
        bus.tag_valid_i = '0;
        bus.tag_dirty_i = '0;
        bus.wb_done_i   = 1'b0;
        bus.inv_gnt_i   = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 32'(bus.busy_o), 0);
        check({tag, "_ack"}, 32'(bus.flush_ack_o), 0);
        check({tag, "_tagreq"}, 32'(bus.tag_req_o), 0);
        check({tag, "_wbreq"}, 32'(bus.wb_req_o), 0);
        check({tag, "_invreq"}, 32'(bus.inv_req_o), 0);
    endtask

    task automatic run_flush(input bit abort_wb, input int forced_set);
        int busy_cyc, exp_cyc, tdly, wdly, idly, rs;
        int tset, wset, wway, iset;
        bit tp, wp, ip, rsp_next, done, aborted;
        logic [NW-1:0] m;
        logic [31:0] perf_exp;
        busy_cyc = 0; tdly = 0; wdly = 0; idly = 0; rs = 0;
        tset = 0; wset = 0; wway = 0; iset = 0;
        tp = 0; wp = 0; ip = 0; rsp_next = 0; done = 0; aborted = 0;

        // Model: per set a tag read, one write-back per valid&dirty way in
        // ascending order, then an invalidate; one response cycle per set
        // and one ack cycle on top of the handshake cycles.
        exp_q.delete();
        exp_cyc = 1;
        for (int s = 0; s < NS; s++) begin
            exp_q.push_back(code(0, s, 0));
            exp_cyc++;
            m = vmem[s] & dmem[s];
            for (int w = 0; w < NW; w++)
                if (m[w]) exp_q.push_back(code(1, s, w));
            exp_q.push_back(code(2, s, 0));
        end

        @(negedge clk);
        bus.flush_i = 1'b1;
        for (int k = 0; k < 3000 && !done; k++) begin
            @(negedge clk);
            if (bus.busy_o) busy_cyc++;
            if (bus.flush_ack_o) begin
                done = 1;
                bus.flush_i = 1'b0;
            end else if (bus.busy_o) begin
                bus.flush_i = 1'($urandom_range(0, 1));
            end

            if (abort_wb && bus.wb_req_o) begin
                bus.wb_done_i = 1'b1;
                #2 rst_n = 1'b0;
                #1 check_quiet("abort");
                check("abort_way", 32'(bus.wb_way_o), 0);
                check("abort_set", 32'(bus.tag_set_o), 0);
                exp_q.delete();
                aborted = 1;
                done = 1;
            end else begin
                if (rsp_next) begin
                    bus.tag_valid_i = vmem[rs];
                    bus.tag_dirty_i = dmem[rs];
                    rsp_next = 0;
                end else begin
                    bus.tag_valid_i = NW'($urandom);
                    bus.tag_dirty_i = NW'($urandom);
                end

                bus.tag_gnt_i = 1'b0;
                if (bus.tag_req_o) begin
                    if (!tp) begin
                        tp = 1;
                        tset = int'(bus.tag_set_o);
                        tdly = (tset == forced_set) ? 3 : $urandom_range(0, maxd);
                        exp_cyc += tdly + 1;
                    end else begin
                        check("tag_set_stable", 32'(bus.tag_set_o), 32'(tset));
                    end
                    if (tdly == 0) begin
                        bus.tag_gnt_i = 1'b1;
                        tp = 0;
                        log_evt(0, tset, 0);
                        rsp_next = 1;
                        rs = tset;
                    end else tdly--;
                end

                bus.wb_done_i = 1'b0;
                if (bus.wb_req_o) begin
                    if (!wp) begin
                        wp = 1;
                        wset = int'(bus.tag_set_o);
                        wway = int'(bus.wb_way_o);
                        wdly = $urandom_range(0, maxd);
                        exp_cyc += wdly + 1;
                    end else begin
                        check("wb_set_stable", 32'(bus.tag_set_o), 32'(wset));
                        check("wb_way_stable", 32'(bus.wb_way_o), 32'(wway));
                    end
                    if (wdly == 0) begin
                        bus.wb_done_i = 1'b1;
                        wp = 0;
                        log_evt(1, wset, wway);
                    end else wdly--;
                end else begin
                    bus.wb_done_i = ($urandom_range(0, 3) == 0);
                end

                bus.inv_gnt_i = 1'b0;
                if (bus.inv_req_o) begin
                    if (!ip) begin
                        ip = 1;
                        iset = int'(bus.tag_set_o);
                        idly = $urandom_range(0, maxd);
                        exp_cyc += idly + 1;
                    end else begin
                        check("inv_set_stable", 32'(bus.tag_set_o), 32'(iset));
                    end
                    if (idly == 0) begin
                        bus.inv_gnt_i = 1'b1;
                        ip = 0;
                        log_evt(2, iset, 0);
                    end else idly--;
                end
            end
        end

        if (aborted) begin
            idle_inputs();
            @(negedge clk);
            rst_n = 1'b1;
            repeat (4) begin
                @(negedge clk);
                check_quiet("post_abort");
            end
        end else begin
            check("ack_seen", 32'(done), 1);
            check("flush_cycles", 32'(busy_cyc), 32'(exp_cyc));
            check("evt_left", 32'(exp_q.size()), 0);
            idle_inputs();
            @(negedge clk);
            check("ack_pulse", 32'(bus.flush_ack_o), 0);
            check("idle_after", 32'(bus.busy_o), 0);
`ifdef DCACHE_FLUSH_PERF_CNT_EN
            perf_exp = 32'(exp_cyc);
`else
            perf_exp = 32'd0;
`endif
            check("perf_cnt", bus.flush_cycles_o, perf_exp);
        end
        check("abort_hit", 32'(aborted), 32'(abort_wb));
    endtask

    task automatic set_mem(input logic [NW-1:0] v, input logic [NW-1:0] d);
        for (int s = 0; s < NS; s++) begin
            vmem[s] = v;
            dmem[s] = d;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        maxd  = 0;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_quiet("rst");
        check("rst_set", 32'(bus.tag_set_o), 0);
        check("rst_way", 32'(bus.wb_way_o), 0);
        check("rst_perf", bus.flush_cycles_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("post_rst");

        // All clean, immediate grants: 3 cycles per set plus ack = 13.
        set_mem('0, '0);
        run_flush(1'b0, -1);

        // Set 2 with two dirty ways: write-backs on ways 1 then 3.
        set_mem('0, '0);
        vmem[2] = 4'b1111;
        dmem[2] = 4'b1010;
        run_flush(1'b0, -1);

        // Tag grant held off on set 1.
        set_mem('0, '0);
        run_flush(1'b0, 1);

        // Dirty but invalid ways are skipped.
        set_mem('0, 4'b1111);
        vmem[0] = 4'b0101;
        run_flush(1'b0, -1);

        // Reset in the middle of a write-back, then a fresh flush.
        set_mem(4'b1111, 4'b1111);
        run_flush(1'b1, -1);
        maxd = 2;
        run_flush(1'b0, -1);

        for (int r = 0; r < 20; r++) begin
            for (int s = 0; s < NS; s++) begin
                vmem[s] = NW'($urandom);
                dmem[s] = NW'($urandom);
            end
            maxd = $urandom_range(0, 3);
            run_flush(1'b0, (r % 5 == 0) ? $urandom_range(0, NS - 1) : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
